// File: rtl/clkscale_arbiter.sv
// clkscale_arbiter: round-robin access to one shared programmable tick divider.
// Bursts are emitted as single-cycle CCLK enables, never as a derived clock.
module clkscale_arbiter #(
   parameter int NREQ = 4,
   parameter int SW   = 32,
   parameter int CW   = 16
) (
   input  logic                 CCLK,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SW-1:0]   scale,
   input  logic [NREQ*CW-1:0]   count,
   output logic [NREQ-1:0]      grant,
   output logic                 tick,
   output logic                 done,
   output logic                 aborted,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_n;
   logic [NREQ-1:0]   grant_n;
   logic [PW-1:0]     ptr, ptr_n, pick;
   logic [SW-1:0]     pe, pe_n, q, q_n, sel_scale;
   logic [CW-1:0]     rem, rem_n, sel_count;
   logic              abt, abt_n, found, live;

   // first asserted request searching upward from the slot after ptr
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int o = 1; o <= NREQ; o++) begin
         if (!found && req[(int'(ptr) + o) % NREQ]) begin
            found = 1'b1;
            pick  = PW'((int'(ptr) + o) % NREQ);
         end
      end
   end

   assign sel_scale = scale[int'(pick)*SW +: SW];
   assign sel_count = count[int'(pick)*CW +: CW];
   assign live      = |(req & grant);

   always_comb begin
      state_n = state;
      grant_n = grant;
      ptr_n   = ptr;
      pe_n    = pe;
      rem_n   = rem;
      q_n     = q;
      abt_n   = abt;
      tick    = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) begin
               ptr_n = pick;
               pe_n  = (sel_scale == '0) ? SW'(1) : sel_scale;
               rem_n = sel_count;
               q_n   = '0;
               abt_n = 1'b0;
               if (sel_count == '0) begin
                  state_n = DONE;
                  grant_n = '0;
               end else begin
                  state_n = RUN;
                  grant_n = NREQ'(1) << pick;
               end
            end
         end
         RUN: begin
            // a dropped request wins over a coincident tick
            if (!live) begin
               state_n = DONE;
               grant_n = '0;
               abt_n   = 1'b1;
            end else if (q == pe - SW'(1)) begin
               tick  = 1'b1;
               q_n   = '0;
               rem_n = rem - CW'(1);
               if (rem == CW'(1)) begin
                  state_n = DONE;
                  grant_n = '0;
               end
            end else begin
               q_n = q + SW'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge CCLK or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= PW'(NREQ - 1);
         pe    <= '0;
         rem   <= '0;
         q     <= '0;
         abt   <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         ptr   <= ptr_n;
         pe    <= pe_n;
         rem   <= rem_n;
         q     <= q_n;
         abt   <= abt_n;
      end
   end

   assign done    = (state == DONE);
   assign aborted = done & abt;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_clkscale_arbiter.sv
// Bench for clkscale_arbiter: directed vector table, corner sequences,
// and a randomized run against a cycle-arithmetic reference model.
module tb_clkscale_arbiter;

   logic          CCLK = 1'b0;
   logic          rst  = 1'b1;
   logic [3:0]    req  = '0;
   logic [127:0]  scale = '0;
   logic [63:0]   count = '0;
   logic [3:0]    grant;
   logic          tick, done, aborted, busy;

   int vectors = 0;
   int miscompares = 0;

   clkscale_arbiter #(.NREQ(4), .SW(32), .CW(16)) dut (
      .CCLK(CCLK), .rst(rst), .req(req), .scale(scale), .count(count),
      .grant(grant), .tick(tick), .done(done), .aborted(aborted),
      .busy(busy)
   );

   always #5 CCLK = ~CCLK;

   typedef struct {
      logic [3:0]  rq;
      logic [31:0] sc;
      logic [15:0] cn;
      logic [3:0]  g;
      logic        t, d, a, b;
   } vec_t;

   vec_t tbl[$];

   function automatic void row(logic [3:0] rq, logic [31:0] sc,
                               logic [15:0] cn, logic [3:0] g,
                               logic t, logic d, logic a, logic b);
      vec_t v;
      v.rq = rq; v.sc = sc; v.cn = cn;
      v.g = g; v.t = t; v.d = d; v.a = a; v.b = b;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      repeat (2) @(posedge CCLK);
      #1 rst = 1'b0;
   endtask

   task automatic wait_grant(input logic [3:0] exp, input string nm);
      int n = 0;
      @(negedge CCLK);
      while (grant == 4'b0 && n < 30) begin
         @(negedge CCLK);
         n++;
      end
      chk(nm, {28'b0, grant}, {28'b0, exp});
   endtask

   logic [3:0] rr [5];

   initial begin
      int nt;
      int mst, mptr, mcur, mg, mpe, mn, mabt, cyc, e, idx;
      logic found;
      logic [3:0] eg;
      logic et, ed, ea, eb;

      // single requester, scale 3 / count 4; values changed after grant
      row(4'b0001, 3, 4, 4'b0000, 0, 0, 0, 0);
      for (int r = 1; r <= 12; r++)
         row(4'b0001, 9, 1, 4'b0001, (r % 3) == 0, 0, 0, 1);
      row(4'b0000, 0, 0, 4'b0000, 0, 1, 0, 1);
      row(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
      // scale 0 behaves as period 1
      row(4'b0001, 0, 3, 4'b0000, 0, 0, 0, 0);
      for (int r = 0; r < 3; r++)
         row(4'b0001, 5, 5, 4'b0001, 1, 0, 0, 1);
      row(4'b0000, 0, 0, 4'b0000, 0, 1, 0, 1);
      row(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
      // zero-tick burst
      row(4'b0001, 0, 0, 4'b0000, 0, 0, 0, 0);
      row(4'b0000, 0, 0, 4'b0000, 0, 1, 0, 1);
      row(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);

      @(negedge CCLK);
      chk("reset_state", {24'b0, grant, tick, done, aborted, busy}, 32'b0);

      do_reset();
      foreach (tbl[i]) begin
         @(posedge CCLK);
         #1;
         req = tbl[i].rq;
         scale[31:0] = tbl[i].sc;
         count[15:0] = tbl[i].cn;
         @(negedge CCLK);
         chk($sformatf("table[%0d]", i),
             {24'b0, grant, tick, done, aborted, busy},
             {24'b0, tbl[i].g, tbl[i].t, tbl[i].d, tbl[i].a, tbl[i].b});
      end

      // round-robin fairness
      rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         scale[i*32 +: 32] = 1;
         count[i*16 +: 16] = 1;
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(rr[k], $sformatf("rr_grant[%0d]", k));
         chk($sformatf("rr_tick[%0d]", k), {31'b0, tick}, 1);
         @(negedge CCLK);
         chk($sformatf("rr_done[%0d]", k), {27'b0, grant, done}, 1);
      end

      // abort of requester 2, requester 3 waiting
      do_reset();
      scale[2*32 +: 32] = 10;
      count[2*16 +: 16] = 5;
      scale[3*32 +: 32] = 2;
      count[3*16 +: 16] = 2;
      req = 4'b1100;
      wait_grant(4'b0100, "abort_grant");
      nt = int'(tick);
      for (int i = 1; i < 20; i++) begin
         @(negedge CCLK);
         nt += int'(tick);
      end
      chk("abort_ticks_before", nt, 2);
      @(posedge CCLK);
      #1 req[2] = 1'b0;
      @(negedge CCLK);
      chk("abort_cycle", {26'b0, grant, tick, done}, {26'b0, 4'b0100, 2'b00});
      @(negedge CCLK);
      chk("abort_done", {25'b0, grant, tick, done, aborted},
          {25'b0, 4'b0000, 3'b011});
      @(negedge CCLK);
      chk("abort_idle", {31'b0, busy}, 0);
      @(negedge CCLK);
      chk("abort_next", {28'b0, grant}, {28'b0, 4'b1000});

      // asynchronous reset in the middle of a burst
      do_reset();
      scale[31:0] = 5;
      count[15:0] = 5;
      req = 4'b0001;
      wait_grant(4'b0001, "rst_grant");
      repeat (3) @(negedge CCLK);
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {24'b0, grant, tick, done, aborted, busy}, 32'b0);
      @(posedge CCLK);
      #1;
      chk("rst_no_done", {24'b0, grant, tick, done, aborted, busy}, 32'b0);
      req = 4'b0010;
      #1 rst = 1'b0;
      wait_grant(4'b0010, "rst_then_1");
      do_reset();
      req = 4'b0011;
      wait_grant(4'b0001, "rst_then_0");

      // randomized run against the reference model
      do_reset();
      mst = 0; mptr = 3; mcur = 0; mg = 0; mpe = 1; mn = 0; mabt = 0;
      cyc = 0; e = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge CCLK);
         #1;
         for (int i = 0; i < 4; i++) begin
            if (!req[i]) begin
               if ($urandom_range(3) == 0) req[i] = 1'b1;
            end else if ($urandom_range(39) == 0) begin
               req[i] = 1'b0;
            end
            scale[i*32 +: 32] = $urandom_range(4);
            count[i*16 +: 16] = 16'($urandom_range(3));
         end
         if (mst == 2 && $urandom_range(1) == 0) req[mcur] = 1'b0;
         @(negedge CCLK);
         eg = '0; et = 0; ed = 0; ea = 0; eb = (mst != 0);
         if (mst == 1) begin
            eg = 4'(1 << mcur);
            e  = cyc - mg + 1;
            et = req[mcur] && (e % mpe == 0);
         end
         if (mst == 2) begin
            ed = 1'b1;
            ea = (mabt != 0);
         end
         chk($sformatf("rand[%0d]", c),
             {24'b0, grant, tick, done, aborted, busy},
             {24'b0, eg, et, ed, ea, eb});
         case (mst)
            0: if (req != 0) begin
               found = 1'b0;
               idx = 0;
               for (int o = 1; o <= 4; o++) begin
                  if (!found && req[(mptr + o) % 4]) begin
                     found = 1'b1;
                     idx = (mptr + o) % 4;
                  end
               end
               mptr = idx;
               mcur = idx;
               mpe  = (scale[idx*32 +: 32] == 0) ? 1 : int'(scale[idx*32 +: 32]);
               mn   = int'(count[idx*16 +: 16]);
               mg   = cyc + 1;
               mabt = 0;
               mst  = (mn == 0) ? 2 : 1;
            end
            1: begin
               if (!req[mcur]) begin
                  mst = 2;
                  mabt = 1;
               end else if (et && (e / mpe) == mn) begin
                  mst = 2;
               end
            end
            default: mst = 0;
         endcase
         cyc++;
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
